// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared pipeline types: hazard FSM states and memory-busy helper
package rv32i_types;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2,
    MEM_WAIT = 2'd3
  } hazard_state_t;

  // A memory is busy while a request is outstanding and its completion has not arrived.
  function automatic logic mem_busy_f(input logic imem_read, input logic imem_resp,
                                      input logic dmem_read, input logic dmem_write,
                                      input logic dmem_resp);
    return (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for hazard performance counters
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/bubble controller
// HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       state
);

  hazard_state_t state_q, state_d;
  logic          mem_busy;

  assign mem_busy = mem_busy_f(imem_read, imem_resp, dmem_read, dmem_write, dmem_resp);
  assign state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, even with a miss pending.
  always_comb begin
    state_d       = state_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
    end else if (mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_stall = 1'b1;
      state_d      = MEM_WAIT;
    end else begin
      unique case (state_q)
        RUN, MEM_WAIT: begin
          if (load_use) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = LU_STALL;
          end else if (br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = REDIRECT;
          end else begin
            state_d = RUN;
          end
        end
        // The dependent instruction has just been released; load_use is stale here.
        LU_STALL: begin
          if (br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = REDIRECT;
          end else begin
            state_d = RUN;
          end
        end
        // EX holds the flushed bubble, so its hazard signals are meaningless.
        REDIRECT: begin
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_flush),
    .count (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // {pc, if_id, id_ex, ex_mem, mem_wb stall, if_id_flush, id_ex_flush, ex_mem_bubble}
  localparam logic [7:0] CTL_NONE  = 8'b00000_000;
  localparam logic [7:0] CTL_LU    = 8'b11100_001;
  localparam logic [7:0] CTL_FLUSH = 8'b00000_110;
  localparam logic [7:0] CTL_MEM   = 8'b11111_000;

  localparam logic [1:0] S_RUN = 2'd0, S_LU = 2'd1, S_RED = 2'd2, S_MEM = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  logic load_use, br_taken, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic if_id_flush, id_ex_flush, ex_mem_bubble;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [1:0] state;
  logic [7:0] ctl;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                if_id_flush, id_ex_flush, ex_mem_bubble};

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_use      (load_use),
    .br_taken      (br_taken),
    .imem_read     (imem_read),
    .imem_resp     (imem_resp),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_resp     (dmem_resp),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .id_ex_stall   (id_ex_stall),
    .ex_mem_stall  (ex_mem_stall),
    .mem_wb_stall  (mem_wb_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_bubble (ex_mem_bubble),
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events),
    .state         (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are changed here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    load_use = 0; br_taken = 0; imem_read = 0; imem_resp = 0;
    dmem_read = 0; dmem_write = 0; dmem_resp = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] perf(input int n);
    return (PERF != 0) ? 32'(n) : 32'd0;
  endfunction

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    check("rst_state", 32'(state), 32'(S_RUN));
    check("rst_ctl", 32'(ctl), 32'(CTL_NONE));
    dmem_read = 1;
    settle();
    check("rst_ctl_miss", 32'(ctl), 32'(CTL_NONE));
    check("rst_stall_cnt", 32'(stall_cycles), 32'd0);
    check("rst_flush_cnt", 32'(flush_events), 32'd0);
    cyc();
    check("rst_state_hold", 32'(state), 32'(S_RUN));

    // Load-use in RUN
    do_reset();
    load_use = 1;
    settle();
    check("lu_c1_ctl", 32'(ctl), 32'(CTL_LU));
    check("lu_c1_state", 32'(state), 32'(S_RUN));
    cyc(); load_use = 0; settle();
    check("lu_c2_state", 32'(state), 32'(S_LU));
    check("lu_c2_ctl", 32'(ctl), 32'(CTL_NONE));
    cyc(); settle();
    check("lu_c3_state", 32'(state), 32'(S_RUN));
    check("lu_stall_cnt", 32'(stall_cycles), perf(1));

    // Taken branch, held a second cycle
    do_reset();
    br_taken = 1;
    settle();
    check("br_c1_ctl", 32'(ctl), 32'(CTL_FLUSH));
    cyc(); settle();
    check("br_c2_state", 32'(state), 32'(S_RED));
    check("br_c2_ctl_ignored", 32'(ctl), 32'(CTL_NONE));
    cyc(); br_taken = 0; settle();
    check("br_c3_state", 32'(state), 32'(S_RUN));
    check("br_flush_cnt", 32'(flush_events), perf(1));
    check("br_stall_cnt", 32'(stall_cycles), 32'd0);

    // Data miss for 5 cycles, resp on the 6th
    do_reset();
    dmem_read = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("dmiss_ctl_%0d", i), 32'(ctl), 32'(CTL_MEM));
      check($sformatf("dmiss_state_%0d", i), 32'(state), (i == 0) ? 32'(S_RUN) : 32'(S_MEM));
      cyc();
    end
    dmem_resp = 1;
    settle();
    check("dmiss_resp_ctl", 32'(ctl), 32'(CTL_NONE));
    check("dmiss_resp_state", 32'(state), 32'(S_MEM));
    cyc(); dmem_read = 0; dmem_resp = 0; settle();
    check("dmiss_done_state", 32'(state), 32'(S_RUN));
    check("dmiss_stall_cnt", 32'(stall_cycles), perf(5));

    // Instruction miss ending with a branch evaluated on the resp cycle
    do_reset();
    imem_read = 1;
    cyc(); cyc();
    imem_resp = 1; br_taken = 1; settle();
    check("imiss_resp_state", 32'(state), 32'(S_MEM));
    check("imiss_resp_flush", 32'(ctl), 32'(CTL_FLUSH));
    cyc(); imem_read = 0; imem_resp = 0; br_taken = 0; settle();
    check("imiss_redirect", 32'(state), 32'(S_RED));

    // Simultaneous load-use and branch
    do_reset();
    load_use = 1; br_taken = 1; settle();
    check("sim_c1_ctl", 32'(ctl), 32'(CTL_LU));
    cyc(); settle();
    check("sim_c2_state", 32'(state), 32'(S_LU));
    check("sim_c2_ctl", 32'(ctl), 32'(CTL_FLUSH));
    cyc(); settle();
    check("sim_c3_state", 32'(state), 32'(S_RED));
    check("sim_c3_ctl", 32'(ctl), 32'(CTL_NONE));
    cyc(); load_use = 0; br_taken = 0; settle();
    check("sim_c4_state", 32'(state), 32'(S_RUN));
    check("sim_flush_cnt", 32'(flush_events), perf(1));
    check("sim_stall_cnt", 32'(stall_cycles), perf(1));

    // Asynchronous reset during a data-write miss
    do_reset();
    dmem_write = 1;
    cyc(); cyc(); settle();
    check("rmm_state_pre", 32'(state), 32'(S_MEM));
    check("rmm_cnt_pre", 32'(stall_cycles), perf(2));
    rst_n = 1'b0;
    settle();
    check("rmm_state", 32'(state), 32'(S_RUN));
    check("rmm_ctl", 32'(ctl), 32'(CTL_NONE));
    check("rmm_cnt", 32'(stall_cycles), 32'd0);
    cyc();
    rst_n = 1'b1; settle();
    check("rmm_release_ctl", 32'(ctl), 32'(CTL_MEM));
    cyc();
    check("rmm_first_edge", 32'(state), 32'(S_MEM));
    dmem_write = 0;

    // Saturation with a 20-cycle instruction miss
    do_reset();
    imem_read = 1;
    repeat (20) cyc();
    settle();
    check("sat_stall", 32'(pc_stall), 32'd1);
    check("sat_cnt_20", 32'(stall_cycles), perf(15));
    repeat (3) cyc();
    check("sat_cnt_hold", 32'(stall_cycles), perf(15));
    imem_read = 0;
    cyc(); cyc();
    check("sat_final_state", 32'(state), 32'(S_RUN));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the performance counters.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 load_use  input  1  load-use hazard: load in MEM, dependent instruction in EX (sel_D from data_forwarding).
REQ-005 br_taken  input  1  EX-stage redirect: taken branch, jal or jalr.
REQ-006 imem_read, imem_resp  input  1 each  instruction-memory request and completion.
REQ-007 dmem_read, dmem_write, dmem_resp  input  1 each  data-memory request and completion.
REQ-008 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  output  1 each  hold the named register.
REQ-009 if_id_flush, id_ex_flush, ex_mem_bubble  output  1 each  load a NOP (all-zero control word) into the named register.
REQ-010 stall_cycles, flush_events  output  CNT_W each  performance counters.
REQ-011 state  output  2  current FSM state, for debug.

Function
REQ-012 The block SHALL implement the states RUN, LU_STALL, REDIRECT and MEM_WAIT.
REQ-013 mem_busy SHALL equal (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp).
REQ-014 Priority in every state SHALL be mem_busy, then load_use, then br_taken.
REQ-015 When mem_busy is high, all five stall outputs SHALL be high and all flush/bubble outputs low, combinationally in the same cycle.
REQ-016 When mem_busy is high, the state SHALL go to MEM_WAIT; MEM_WAIT SHALL return to RUN on the first cycle mem_busy is low, and hazard inputs SHALL be evaluated in that cycle.
REQ-017 In RUN with load_use high and mem_busy low: pc_stall, if_id_stall and id_ex_stall SHALL be high, ex_mem_bubble high, and next state LU_STALL.
REQ-018 LU_STALL SHALL last exactly one cycle; load_use SHALL be ignored in it, and br_taken SHALL be honoured per REQ-019.
REQ-019 In RUN or LU_STALL with br_taken high, load_use low (or ignored) and mem_busy low: if_id_flush and id_ex_flush SHALL be high, no stalls, and next state REDIRECT.
REQ-020 In REDIRECT, br_taken and load_use SHALL be ignored (EX holds a bubble); the state SHALL return to RUN after one cycle unless mem_busy is high.
REQ-021 If br_taken and load_use are high together in RUN, the load-use stall SHALL win, and the branch SHALL be re-evaluated the following cycle.
REQ-022 All control outputs SHALL be combinational from state and inputs, with no extra latency; state SHALL be registered.

Reset
REQ-023 When rst_n is low, state SHALL become RUN immediately, regardless of any pending memory or hazard condition.
REQ-024 During reset, all stall/flush/bubble outputs SHALL be 0 and counters SHALL be 0.
REQ-025 The first edge after rst_n deasserts SHALL evaluate inputs normally.

Configuration
REQ-026 With HAZARD_PERF_EN defined, stall_cycles SHALL increment on every cycle pc_stall is high.
REQ-027 With HAZARD_PERF_EN defined, flush_events SHALL increment on every cycle if_id_flush is high.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 Without HAZARD_PERF_EN, both counters SHALL be constant 0 and contain no registers.

Structure
REQ-030 The hazard_state_t enum (RUN, LU_STALL, REDIRECT, MEM_WAIT) SHALL live in rv32i_types.
REQ-031 The counters SHALL use one sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output count).

Verification
REQ-032 Load-use: load_use=1 for 1 cycle in RUN -> pc/if_id/id_ex stall=1 and ex_mem_bubble=1 for 1 cycle; state LU_STALL then RUN; stall_cycles=1.
REQ-033 Branch: br_taken=1 in RUN -> if_id_flush=id_ex_flush=1 for 1 cycle; state REDIRECT then RUN; a br_taken held a second cycle is ignored; flush_events=1.
REQ-034 Data miss: dmem_read=1, dmem_resp=0 for 5 cycles then 1 -> all stalls high for 5 cycles, state MEM_WAIT, stall_cycles=5, RUN on the resp cycle.
REQ-035 Simultaneous: load_use=1 and br_taken=1 -> cycle 1 load-use stall only; cycle 2 (br_taken still 1) flush; state RUN->LU_STALL->REDIRECT->RUN.
REQ-036 Reset mid-miss: assert rst_n=0 during MEM_WAIT -> outputs 0 and state RUN asynchronously, counters 0.
REQ-037 Saturation: build with CNT_W=4 and HAZARD_PERF_EN, hold imem miss 20 cycles -> stall_cycles=15 and stays 15.
